// File: rtl/md_issue_if.sv
// E-stage <-> multiply/divide issue bundle: instruction/operands in, unit start/op/operands out,
// HI/LO read-back and stall. master drives the instruction and unit status; slave is md_issue_ctrl.
interface md_issue_if #(
   parameter int DW = 32
);
   logic          op_valid;
   logic [3:0]    op_code;
   logic [DW-1:0] rs_val;
   logic [DW-1:0] rt_val;
   logic          md_busy;
   logic [DW-1:0] md_hi;
   logic [DW-1:0] md_lo;
   logic          md_start;
   logic [2:0]    md_op;
   logic [DW-1:0] md_a;
   logic [DW-1:0] md_b;
   logic          stall;
   logic [DW-1:0] rd_data;
   logic          err_timeout;

   modport master (
      output op_valid, op_code, rs_val, rt_val, md_busy, md_hi, md_lo,
      input  md_start, md_op, md_a, md_b, stall, rd_data, err_timeout
   );

   modport slave (
      input  op_valid, op_code, rs_val, rt_val, md_busy, md_hi, md_lo,
      output md_start, md_op, md_a, md_b, stall, rd_data, err_timeout
   );
endinterface

// File: rtl/md_issue_ctrl.sv
// Mul/div issue control: registered start/op/operands one cycle after accept; stall is combinational
// while LAUNCH/WAIT/MTW is outstanding. MD_STALL_CNT_EN adds stall_cycles/md_ops counters.
module md_issue_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int DW      = 32
) (
   input logic        clk,
   input logic        rst,
   md_issue_if.slave  bus
`ifdef MD_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] md_ops
`endif
);
   localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

   localparam logic [2:0] MUDI_NONE  = 3'd0;
   localparam logic [2:0] MUDI_MULT  = 3'd1;
   localparam logic [2:0] MUDI_MULTU = 3'd2;
   localparam logic [2:0] MUDI_DIV   = 3'd3;
   localparam logic [2:0] MUDI_DIVU  = 3'd4;
   localparam logic [2:0] MUDI_MTHI  = 3'd5;
   localparam logic [2:0] MUDI_MTLO  = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_MTW} state_t;

   state_t        state, state_nxt;
   logic          is_compute, is_mt, is_mf, md_class;
   logic          acc_compute, acc_mt;
   logic          stall_c;
   logic [DW-1:0] rd_c;
   logic [2:0]    op_mudi;
   logic          start_q;
   logic [2:0]    op_q;
   logic [DW-1:0] a_q, b_q;
   logic [CW-1:0] wait_cnt;
   logic          err_q;

   always_comb begin : decode
      is_compute = bus.op_valid && (bus.op_code >= 4'd1) && (bus.op_code <= 4'd4);
      is_mt      = bus.op_valid && ((bus.op_code == 4'd5) || (bus.op_code == 4'd6));
      is_mf      = bus.op_valid && ((bus.op_code == 4'd7) || (bus.op_code == 4'd8));
      md_class   = is_compute || is_mt || is_mf;
      op_mudi    = MUDI_NONE;
      case (bus.op_code)
         4'd1:    op_mudi = MUDI_MULT;
         4'd2:    op_mudi = MUDI_MULTU;
         4'd3:    op_mudi = MUDI_DIV;
         4'd4:    op_mudi = MUDI_DIVU;
         4'd5:    op_mudi = MUDI_MTHI;
         4'd6:    op_mudi = MUDI_MTLO;
         default: op_mudi = MUDI_NONE;
      endcase
   end

   always_ff @(posedge clk) begin : state_reg
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin : next_state
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (acc_compute)  state_nxt = S_LAUNCH;
            else if (acc_mt)  state_nxt = S_MTW;
         end
         S_LAUNCH: state_nxt = S_WAIT;
         S_WAIT:   if (!bus.md_busy) state_nxt = S_IDLE;
         S_MTW:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // mf reads HI/LO straight from the unit; only legal in IDLE, where no write is pending
   always_comb begin : outputs
      stall_c     = md_class && (state != S_IDLE);
      acc_compute = is_compute && (state == S_IDLE);
      acc_mt      = is_mt && (state == S_IDLE);
      rd_c        = '0;
      if ((state == S_IDLE) && is_mf)
         rd_c = (bus.op_code == 4'd7) ? bus.md_hi : bus.md_lo;
   end

   always_ff @(posedge clk) begin : issue_regs
      if (rst) begin
         start_q <= 1'b0;
         op_q    <= MUDI_NONE;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         start_q <= acc_compute;
         op_q    <= (acc_compute || acc_mt) ? op_mudi : MUDI_NONE;
         if (acc_compute) begin
            a_q <= bus.rs_val;
            b_q <= bus.rt_val;
         end else if (acc_mt) begin
            a_q <= bus.rs_val;
         end
      end
   end

   // wait_cnt counts busy cycles seen in WAIT and parks at all-ones
   always_ff @(posedge clk) begin : wait_timer
      if (rst) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else if (state == S_LAUNCH) begin
         wait_cnt <= '0;
      end else if ((state == S_WAIT) && bus.md_busy) begin
         if (wait_cnt == TO_CNT) err_q <= 1'b1;
         if (wait_cnt != {CW{1'b1}}) wait_cnt <= wait_cnt + 1'b1;
      end
   end

`ifdef MD_STALL_CNT_EN
   always_ff @(posedge clk) begin : perf_cnt
      if (rst) begin
         stall_cycles <= '0;
         md_ops       <= '0;
      end else begin
         if (stall_c) stall_cycles <= stall_cycles + 32'd1;
         if (acc_compute || acc_mt) md_ops <= md_ops + 32'd1;
      end
   end
`endif

   assign bus.md_start    = start_q;
   assign bus.md_op       = op_q;
   assign bus.md_a        = a_q;
   assign bus.md_b        = b_q;
   assign bus.stall       = stall_c;
   assign bus.rd_data     = rd_c;
   assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a behavioural mul/div unit (4 busy cycles) and an
// expected-result queue for mfhi/mflo reads.
module tb_md_issue_ctrl;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst;
   logic force_busy;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [31:0] exp_q[$];

   md_issue_if #(.DW(32)) bus ();

`ifdef MD_STALL_CNT_EN
   logic [31:0] stall_cycles, md_ops;
   int          sc_model = 0;
   int          ops_model = 0;
   md_issue_ctrl #(.TIMEOUT(15), .DW(32)) dut (
      .clk(clk), .rst(rst), .bus(bus), .stall_cycles(stall_cycles), .md_ops(md_ops));
   always @(negedge clk) begin
      if (rst)            sc_model <= 0;
      else if (bus.stall) sc_model <= sc_model + 1;
   end
`else
   md_issue_ctrl #(.TIMEOUT(15), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   // behavioural multiply/divide unit
   logic               u_busy;
   int                 u_cnt;
   logic [31:0]        u_hi, u_lo, p_hi, p_lo, r_hi, r_lo;
   logic signed [63:0] ea, eb;
   logic signed [31:0] sa, sb;

   always_comb begin
      ea = {{32{bus.md_a[31]}}, bus.md_a};
      eb = {{32{bus.md_b[31]}}, bus.md_b};
      sa = bus.md_a;
      sb = bus.md_b;
      r_hi = '0;
      r_lo = '0;
      case (bus.md_op)
         3'd1: {r_hi, r_lo} = ea * eb;
         3'd2: {r_hi, r_lo} = {32'd0, bus.md_a} * {32'd0, bus.md_b};
         3'd3: if (sb != 0) begin r_lo = sa / sb; r_hi = sa % sb; end
         3'd4: if (bus.md_b != 0) begin r_lo = bus.md_a / bus.md_b; r_hi = bus.md_a % bus.md_b; end
         default: ;
      endcase
   end

   always @(posedge clk) begin
      if (rst) begin
         u_busy <= 1'b0; u_cnt <= 0; u_hi <= '0; u_lo <= '0; p_hi <= '0; p_lo <= '0;
      end else if (bus.md_start) begin
         u_busy <= 1'b1; u_cnt <= LAT - 1; p_hi <= r_hi; p_lo <= r_lo;
      end else if (u_busy) begin
         if (u_cnt == 0) begin
            u_busy <= 1'b0; u_hi <= p_hi; u_lo <= p_lo;
         end else begin
            u_cnt <= u_cnt - 1;
         end
      end else if (bus.md_op == 3'd5) begin
         u_hi <= bus.md_a;
      end else if (bus.md_op == 3'd6) begin
         u_lo <= bus.md_a;
      end
   end

   assign bus.md_busy = u_busy | force_busy;
   assign bus.md_hi   = u_hi;
   assign bus.md_lo   = u_lo;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // present an op, hold it through any stall, pop the scoreboard on mf acceptance
   task automatic issue(input string tag, input logic [3:0] code, input logic [31:0] rs,
                        input logic [31:0] rt, output int stalls);
      logic [31:0] e;
      bus.op_valid = 1'b1;
      bus.op_code  = code;
      bus.rs_val   = rs;
      bus.rt_val   = rt;
      stalls       = 0;
      @(negedge clk);
      while (bus.stall === 1'b1 && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (bus.stall !== 1'b0) chk({tag, "_stall_bound"}, 32'(bus.stall), 32'd0);
      if (code == 4'd7 || code == 4'd8) begin
         n_cmp++;
         assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed %h required queued entry", tag, bus.rd_data);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, bus.rd_data, e);
         end
      end
`ifdef MD_STALL_CNT_EN
      if (code >= 4'd1 && code <= 4'd6) ops_model++;
`endif
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      bus.op_code  = 4'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish before 100000ns");
      $fatal(1);
   end

   initial begin
      int st;
      rst = 1'b1; force_busy = 1'b0;
      bus.op_valid = 1'b0; bus.op_code = 4'd0; bus.rs_val = '0; bus.rt_val = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start", 32'(bus.md_start), 32'd0);
      chk("rst_op", 32'(bus.md_op), 32'd0);
      chk("rst_a", bus.md_a, 32'd0);
      chk("rst_b", bus.md_b, 32'd0);
      chk("rst_err", 32'(bus.err_timeout), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // MULT -2*3 followed immediately by MFLO/MFHI
      issue("mult", 4'd1, 32'hFFFFFFFE, 32'd3, st);
      chk("mult_stalls", 32'(st), 32'd0);
      chk("mult_start", 32'(bus.md_start), 32'd1);
      chk("mult_op", 32'(bus.md_op), 32'd1);
      chk("mult_a", bus.md_a, 32'hFFFFFFFE);
      chk("mult_b", bus.md_b, 32'd3);
      exp_q.push_back(32'hFFFFFFFA);
      issue("mflo_mult", 4'd8, 32'd0, 32'd0, st);
      chk("mflo_mult_stalls", 32'(st), 32'(LAT + 2));
      chk("after_launch_start", 32'(bus.md_start), 32'd0);
      exp_q.push_back(32'hFFFFFFFF);
      issue("mfhi_mult", 4'd7, 32'd0, 32'd0, st);
      chk("mfhi_mult_stalls", 32'(st), 32'd0);

      // DIVU 100/7 with non-MD ops in its shadow
      issue("divu", 4'd4, 32'd100, 32'd7, st);
      for (int i = 0; i < 4; i++) begin
         issue("add", (i % 2 == 1) ? 4'd12 : 4'd0, 32'(i), 32'(i), st);
         chk("add_stalls", 32'(st), 32'd0);
      end
      exp_q.push_back(32'd2);
      issue("mfhi_divu", 4'd7, 32'd0, 32'd0, st);
      chk("mfhi_divu_stalls", 32'(st), 32'd2);
      exp_q.push_back(32'd14);
      issue("mflo_divu", 4'd8, 32'd0, 32'd0, st);

      // MTHI then MFHI
      issue("mthi", 4'd5, 32'h1234, 32'd0, st);
      chk("mthi_op", 32'(bus.md_op), 32'd5);
      chk("mthi_start", 32'(bus.md_start), 32'd0);
      chk("mthi_a", bus.md_a, 32'h1234);
      exp_q.push_back(32'h1234);
      issue("mfhi_mt", 4'd7, 32'd0, 32'd0, st);
      chk("mfhi_mt_stalls", 32'(st), 32'd1);

      // MTLO arriving while DIV -20/3 runs
      issue("div", 4'd3, 32'hFFFFFFEC, 32'd3, st);
      issue("mtlo", 4'd6, 32'hABCD, 32'd0, st);
      chk("mtlo_stalls", 32'(st), 32'(LAT + 2));
      chk("mtlo_op", 32'(bus.md_op), 32'd6);
      exp_q.push_back(32'hABCD);
      issue("mflo_mt", 4'd8, 32'd0, 32'd0, st);
      chk("mflo_mt_stalls", 32'(st), 32'd1);
      exp_q.push_back(32'hFFFFFFFE);
      issue("mfhi_div", 4'd7, 32'd0, 32'd0, st);

`ifdef MD_STALL_CNT_EN
      chk("stall_cycles_mid", stall_cycles, 32'(sc_model));
      chk("md_ops_mid", md_ops, 32'(ops_model));
`endif

      // reset in the middle of a MULTU wait
      issue("multu", 4'd2, 32'd5, 32'd7, st);
      repeat (2) @(posedge clk);
      #1;
      chk("multu_in_wait_start", 32'(bus.md_start), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`ifdef MD_STALL_CNT_EN
      ops_model = 0;
`endif
      chk("midrst_start", 32'(bus.md_start), 32'd0);
      chk("midrst_op", 32'(bus.md_op), 32'd0);
      chk("midrst_a", bus.md_a, 32'd0);
      chk("midrst_b", bus.md_b, 32'd0);
      exp_q.push_back(32'd0);
      issue("mfhi_midrst", 4'd7, 32'd0, 32'd0, st);
      chk("mfhi_midrst_stalls", 32'(st), 32'd0);

      // unit held busy for 20 cycles after launch
      force_busy = 1'b1;
      issue("mult_to", 4'd1, 32'h10000, 32'h10000, st);
      bus.op_valid = 1'b1;
      bus.op_code  = 4'd7;
      repeat (13) @(posedge clk);
      #1;
      chk("to_err_early", 32'(bus.err_timeout), 32'd0);
      chk("to_stall_held", 32'(bus.stall), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      chk("to_err_set", 32'(bus.err_timeout), 32'd1);
      repeat (1) @(posedge clk);
      #1;
      force_busy = 1'b0;
      exp_q.push_back(32'd1);
      issue("mfhi_to", 4'd7, 32'd0, 32'd0, st);
      chk("mfhi_to_stalls", 32'(st), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("to_err_sticky", 32'(bus.err_timeout), 32'd1);
`ifdef MD_STALL_CNT_EN
      chk("stall_cycles_end", stall_cycles, 32'(sc_model));
      chk("md_ops_end", md_ops, 32'(ops_model));
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("to_err_cleared", 32'(bus.err_timeout), 32'd0);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
